// File: rtl/pakin_pkg.sv
// Shared constants and helpers for the packet reassembler (pakin).
// Holds the default packet/message geometry, debounce lengths and width helpers.
package pakin_pkg;

    localparam int NS_PACKET_SIZE  = 8;
    localparam int NS_ADDRESS_SIZE = 8;
    localparam int NS_DATA_SIZE    = 8;
    localparam int NS_REDUN_SIZE   = 8;
    localparam int NS_FULL_MSG_SZ  = NS_ADDRESS_SIZE + NS_DATA_SIZE
                                   + NS_REDUN_SIZE;
    localparam int NS_REQ_CKS      = 1;
    localparam int NS_ACK_CKS      = 1;

    typedef enum logic [1:0] {
        RX_WAIT  = 2'd0,
        RX_LATCH = 2'd1,
        RX_ACKED = 2'd2
    } rx_state_t;

    // Number of packets needed to carry a message of m bits.
    function automatic int tot_pks(input int m, input int p);
        return (m + p - 1) / p;
    endfunction

    // Bits needed to count 0..n, never less than one.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pakin_fifo.sv
// Message FIFO for pakin: D entries of W bits, head/tail pointers plus a count.
// Ports: clk, reset (async active-low), push/push_data, pop/pop_data, full, empty.
module pakin_fifo
    import pakin_pkg::*;
#(
    parameter int W = NS_FULL_MSG_SZ,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(D);

    logic [W-1:0]  mem [D];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) head <= head + 1'b1;
            if (pop)  tail <= tail + 1'b1;
            // simultaneous push and pop leave the count alone
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[head] <= push_data;
    end

    assign pop_data = mem[tail];
    assign full     = (count == (AW + 1)'(D));
    assign empty    = (count == '0);

endmodule

// File: rtl/pakin.sv
// pakin: reassembles TOT_PKS packets from a 4-phase req/ack link into messages,
// queues them in a FIFO and forwards each on a second 4-phase req/ack link.
// Ports: i_clk, reset (async active-low), ready, rcv0_pakio/rcv0_req/rcv0_ack
// (packet input side), snd0_msg/snd0_req/snd0_ack (message output side).
module pakin
    import pakin_pkg::*;
#(
    parameter int PSZ         = NS_PACKET_SIZE,
    parameter int ASZ         = NS_ADDRESS_SIZE,
    parameter int DSZ         = NS_DATA_SIZE,
    parameter int RSZ         = NS_REDUN_SIZE,
    parameter int FSZ         = 4,
    parameter int RCV_REQ_CKS = NS_REQ_CKS,
    parameter int SND_ACK_CKS = NS_ACK_CKS
) (
    input  logic                   i_clk,
    input  logic                   reset,
    output logic                   ready,
    input  logic [PSZ-1:0]         rcv0_pakio,
    input  logic                   rcv0_req,
    output logic                   rcv0_ack,
    output logic [ASZ+DSZ+RSZ-1:0] snd0_msg,
    output logic                   snd0_req,
    input  logic                   snd0_ack
);

    localparam int MSZ     = ASZ + DSZ + RSZ;
    localparam int TOT_PKS = tot_pks(MSZ, PSZ);
    localparam int IW      = cnt_w(TOT_PKS - 1);
    localparam int RCW     = cnt_w(RCV_REQ_CKS);
    localparam int ACW     = cnt_w(SND_ACK_CKS);

    // ---------------- debouncers ----------------
    logic           req_db;
    logic           ack_db;
    logic [RCW-1:0] req_cnt;
    logic [ACW-1:0] ack_cnt;

    // The debounced level flips only after CKS consecutive samples that
    // disagree with it; any agreeing sample restarts the run.
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            req_db  <= 1'b0;
            req_cnt <= '0;
        end else if (rcv0_req == req_db) begin
            req_cnt <= '0;
        end else if (req_cnt == RCW'(RCV_REQ_CKS - 1)) begin
            req_db  <= rcv0_req;
            req_cnt <= '0;
        end else begin
            req_cnt <= req_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            ack_db  <= 1'b0;
            ack_cnt <= '0;
        end else if (snd0_ack == ack_db) begin
            ack_cnt <= '0;
        end else if (ack_cnt == ACW'(SND_ACK_CKS - 1)) begin
            ack_db  <= snd0_ack;
            ack_cnt <= '0;
        end else begin
            ack_cnt <= ack_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) ready <= 1'b0;
        else        ready <= 1'b1;
    end

    // ---------------- receive FSM ----------------
    rx_state_t              rx_st;
    rx_state_t              rx_nxt;
    logic [IW-1:0]          pk_idx;
    logic [TOT_PKS*PSZ-1:0] pk_buf;
    logic                   msg_done;
    logic                   latch;
    logic                   push;
    logic                   ack_drop;
    logic                   last_pk;

    logic                   pop;
    logic [MSZ-1:0]         fifo_tail;
    logic                   fifo_full;
    logic                   fifo_empty;

    assign last_pk = (pk_idx == IW'(TOT_PKS - 1));

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) rx_st <= RX_WAIT;
        else        rx_st <= rx_nxt;
    end

    // A completing packet is only taken when the FIFO has room; the push
    // itself happens one clock later in RX_LATCH, when no other push can
    // be pending, so the room check cannot go stale.
    always_comb begin
        rx_nxt   = rx_st;
        latch    = 1'b0;
        push     = 1'b0;
        ack_drop = 1'b0;
        unique case (rx_st)
            RX_WAIT: begin
                if (ready && req_db && (!last_pk || !fifo_full)) begin
                    latch  = 1'b1;
                    rx_nxt = RX_LATCH;
                end
            end
            RX_LATCH: begin
                push   = msg_done;
                rx_nxt = RX_ACKED;
            end
            RX_ACKED: begin
                if (!req_db) begin
                    ack_drop = 1'b1;
                    rx_nxt   = RX_WAIT;
                end
            end
            default: rx_nxt = RX_WAIT;
        endcase
    end

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            pk_idx   <= '0;
            pk_buf   <= '0;
            msg_done <= 1'b0;
            rcv0_ack <= 1'b0;
        end else begin
            if (latch) begin
                pk_buf[pk_idx*PSZ +: PSZ] <= rcv0_pakio;
                rcv0_ack <= 1'b1;
                if (last_pk) begin
                    pk_idx   <= '0;
                    msg_done <= 1'b1;
                end else begin
                    pk_idx   <= pk_idx + 1'b1;
                    msg_done <= 1'b0;
                end
            end else if (ack_drop) begin
                rcv0_ack <= 1'b0;
            end
        end
    end

    // ---------------- message FIFO ----------------
    pakin_fifo #(
        .W (MSZ),
        .D (FSZ)
    ) u_fifo (
        .clk       (i_clk),
        .reset     (reset),
        .push      (push),
        .push_data (pk_buf[MSZ-1:0]),
        .pop       (pop),
        .pop_data  (fifo_tail),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // ---------------- send side ----------------
    assign pop = ready && !snd0_req && !ack_db && !fifo_empty;

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            snd0_msg <= '0;
            snd0_req <= 1'b0;
        end else if (pop) begin
            snd0_msg <= fifo_tail;
            snd0_req <= 1'b1;
        end else if (snd0_req && ack_db) begin
            snd0_req <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pakin.sv
// Self-checking bench for pakin: directed packet streams, scoreboard queue
// filled at issue time and drained by a monitor on the message side.
module tb_pakin;

    logic        clk = 1'b0;
    logic        reset;
    logic        ready;
    logic [7:0]  rcv0_pakio;
    logic        rcv0_req;
    logic        rcv0_ack;
    logic [23:0] snd0_msg;
    logic        snd0_req;
    logic        snd0_ack = 1'b0;

    logic        g_ready;
    logic [7:0]  g_pak;
    logic        g_req;
    logic        g_ack;
    logic [23:0] g_msg;
    logic        g_sreq;
    logic        g_sack = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;
    int n_rx   = 0;
    bit cons_en;
    int cons_dly;
    bit seen_req = 1'b0;
    logic [23:0] last_exp = '0;
    logic [23:0] exp_q[$];

    always #5 clk = ~clk;

    pakin #(
        .PSZ(8), .ASZ(8), .DSZ(8), .RSZ(8), .FSZ(4),
        .RCV_REQ_CKS(1), .SND_ACK_CKS(1)
    ) u_dut (
        .i_clk      (clk),
        .reset      (reset),
        .ready      (ready),
        .rcv0_pakio (rcv0_pakio),
        .rcv0_req   (rcv0_req),
        .rcv0_ack   (rcv0_ack),
        .snd0_msg   (snd0_msg),
        .snd0_req   (snd0_req),
        .snd0_ack   (snd0_ack)
    );

    pakin #(
        .PSZ(8), .ASZ(8), .DSZ(8), .RSZ(8), .FSZ(4),
        .RCV_REQ_CKS(3), .SND_ACK_CKS(1)
    ) u_glt (
        .i_clk      (clk),
        .reset      (reset),
        .ready      (g_ready),
        .rcv0_pakio (g_pak),
        .rcv0_req   (g_req),
        .rcv0_ack   (g_ack),
        .snd0_msg   (g_msg),
        .snd0_req   (g_sreq),
        .snd0_ack   (g_sack)
    );

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    // Monitor: compare each newly presented message with the queue head.
    always @(negedge clk) begin
        if (!reset) begin
            seen_req = 1'b0;
        end else if (snd0_req && !seen_req) begin
            seen_req = 1'b1;
            n_rx++;
            if (exp_q.size() == 0) begin
                chk("unexpected_msg", 32'(snd0_msg), 32'hFFFFFFFF);
            end else begin
                last_exp = exp_q.pop_front();
                chk("msg_data", 32'(snd0_msg), 32'(last_exp));
            end
        end else if (!snd0_req) begin
            seen_req = 1'b0;
        end
    end

    // Consumer: acknowledges presented messages while enabled.
    initial begin
        bit ok;
        forever begin
            @(negedge clk);
            if (cons_en && reset && snd0_req && !snd0_ack) begin
                repeat (cons_dly + 1) @(negedge clk);
                chk("msg_stable", 32'(snd0_msg), 32'(last_exp));
                snd0_ack = 1'b1;
                ok = 1'b0;
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    if (!snd0_req) begin
                        ok = 1'b1;
                        break;
                    end
                end
                chk("snd_req_drop", 32'(ok), 32'd1);
                snd0_ack = 1'b0;
            end
        end
    end

    task automatic wait_ack(input logic lvl, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (rcv0_ack === lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic send_pkt(input logic [7:0] d);
        bit ok;
        @(negedge clk);
        rcv0_pakio = d;
        rcv0_req   = 1'b1;
        wait_ack(1'b1, 40, ok);
        chk("pkt_ack_rise", 32'(ok), 32'd1);
        rcv0_req = 1'b0;
        wait_ack(1'b0, 40, ok);
        chk("pkt_ack_fall", 32'(ok), 32'd1);
    endtask

    task automatic send_msg(input logic [23:0] m);
        exp_q.push_back(m);
        send_pkt(m[7:0]);
        send_pkt(m[15:8]);
        send_pkt(m[23:16]);
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !snd0_req && !snd0_ack) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain", 32'(ok), 32'd1);
    endtask

    task automatic g_send(input logic [7:0] d);
        bit ok;
        @(negedge clk);
        g_pak = d;
        g_req = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (g_ack) begin
                ok = 1'b1;
                break;
            end
        end
        chk("glt_ack_rise", 32'(ok), 32'd1);
        g_req = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!g_ack) begin
                ok = 1'b1;
                break;
            end
        end
        chk("glt_ack_fall", 32'(ok), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] pats [4];
        bit ok;
        bit glitch_ack;
        int base;

        pats[0] = 24'h000000;
        pats[1] = 24'hFFFFFF;
        pats[2] = 24'h123456;
        pats[3] = 24'h80017E;

        reset      = 1'b0;
        rcv0_req   = 1'b0;
        rcv0_pakio = '0;
        g_req      = 1'b0;
        g_pak      = '0;
        cons_en    = 1'b0;
        cons_dly   = 0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_rcv_ack", 32'(rcv0_ack), 32'd0);
        chk("rst_snd_req", 32'(snd0_req), 32'd0);
        chk("rst_snd_msg", 32'(snd0_msg), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("ready_rise", 32'(ready), 32'd1);

        // basic message and latency from the final ack
        cons_en  = 1'b1;
        cons_dly = 1;
        exp_q.push_back(24'h332211);
        send_pkt(8'h11);
        send_pkt(8'h22);
        @(negedge clk);
        rcv0_pakio = 8'h33;
        rcv0_req   = 1'b1;
        wait_ack(1'b1, 40, ok);
        chk("last_ack", 32'(ok), 32'd1);
        @(negedge clk);
        chk("lat_1clk_low", 32'(snd0_req), 32'd0);
        @(negedge clk);
        chk("lat_2clk_high", 32'(snd0_req), 32'd1);
        rcv0_req = 1'b0;
        wait_ack(1'b0, 40, ok);
        chk("last_ack_fall", 32'(ok), 32'd1);
        drain();

        // data patterns
        foreach (pats[i]) send_msg(pats[i]);
        drain();

        // back-pressure: consumer stalled, one message out plus four queued
        cons_en = 1'b0;
        base = n_rx;
        for (int i = 0; i < 5; i++) send_msg(24'hC00000 + 24'(i));
        repeat (4) @(negedge clk);
        chk("bp_presented", 32'(n_rx - base), 32'd1);
        exp_q.push_back(24'hC00005);
        send_pkt(8'h05);
        send_pkt(8'h00);
        @(negedge clk);
        rcv0_pakio = 8'hC0;
        rcv0_req   = 1'b1;
        wait_ack(1'b1, 20, ok);
        chk("bp_stall_no_ack", 32'(ok), 32'd0);
        cons_en = 1'b1;
        wait_ack(1'b1, 80, ok);
        chk("bp_ack_after_pop", 32'(ok), 32'd1);
        rcv0_req = 1'b0;
        wait_ack(1'b0, 40, ok);
        chk("bp_ack_fall", 32'(ok), 32'd1);
        drain();
        chk("bp_total", 32'(n_rx - base), 32'd6);

        // final packet landing near a pop, swept across offsets
        cons_dly = 0;
        for (int off = 0; off < 6; off++) begin
            cons_en = 1'b0;
            base = n_rx;
            send_msg(24'h100000 + 24'(off));
            send_msg(24'h200000 + 24'(off));
            exp_q.push_back(24'h300000 + 24'(off));
            send_pkt(8'(off));
            send_pkt(8'h00);
            fork
                begin
                    repeat (off) @(negedge clk);
                    send_pkt(8'h30);
                end
                cons_en = 1'b1;
            join
            drain();
            chk("coinc_count", 32'(n_rx - base), 32'd3);
        end

        // glitch on the slow-debounce instance
        @(negedge clk);
        g_req = 1'b1;
        repeat (2) @(negedge clk);
        g_req = 1'b0;
        glitch_ack = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (g_ack) glitch_ack = 1'b1;
        end
        chk("glitch_no_ack", 32'(glitch_ack), 32'd0);
        g_send(8'h0A);
        g_send(8'h0B);
        g_send(8'h0C);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (g_sreq) begin
                ok = 1'b1;
                break;
            end
        end
        chk("glitch_msg_req", 32'(ok), 32'd1);
        chk("glitch_msg", 32'(g_msg), 32'h000C0B0A);

        // reset mid-message discards the partial message and queued data
        cons_en = 1'b0;
        send_msg(24'h445566);
        send_pkt(8'h77);
        send_pkt(8'h88);
        send_pkt(8'h99);
        send_pkt(8'h55);
        send_pkt(8'h66);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready", 32'(ready), 32'd0);
        chk("mid_rst_snd_req", 32'(snd0_req), 32'd0);
        chk("mid_rst_snd_msg", 32'(snd0_msg), 32'd0);
        chk("mid_rst_rcv_ack", 32'(rcv0_ack), 32'd0);
        reset = 1'b1;
        cons_en = 1'b1;
        base = n_rx;
        send_msg(24'hC3B2A1);
        drain();
        chk("post_rst_count", 32'(n_rx - base), 32'd1);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
